// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
// Holds the default bus widths, the read-owner encoding and the tag
// payload carried through the read-return pipeline.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // One in-flight read: whether it exists and who issued it.
    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// RD_LAT-deep shift register of read tags, aligned with the RAM read latency.
// Ports:
//   clk, reset : clock and synchronous active-high clear
//   tag_in     : tag of the read granted this cycle (valid=0 when none)
//   tag_out    : tag whose data appears on mem_q this cycle
module rd_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage_q [RD_LAT];

    // Clearing every stage drops in-flight reads on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the
// load/store path. Data has priority, but fetch is served after at most
// MAX_STREAK consecutive data grants while it waits. Reads are tagged with
// their owner and returned RD_LAT cycles after grant, in grant order.
// Ports:
//   if_req/if_addr -> if_gnt, if_rvalid/if_rdata       : fetch requester
//   d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid/d_rdata : data requester
//   mem_ad/mem_d/mem_we -> RAM, mem_q <- RAM            : shared RAM port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int unsigned            STREAK_W   = $clog2(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0]    STREAK_MAX = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] streak_q;
    logic                streak_full;
    rd_tag_t             tag_in;
    rd_tag_t             tag_out;
    logic                ret_valid;

    assign streak_full = (streak_q == STREAK_MAX);

    // Same-cycle grant: data wins a contest unless fetch has waited out a full streak.
    always_comb begin
        d_gnt  = 1'b0;
        if_gnt = 1'b0;
        if (!reset) begin
            d_gnt  = d_req && !(if_req && streak_full);
            if_gnt = if_req && !(d_req && !streak_full);
        end
    end

    // Drive the RAM from whichever side won; idle port is all-zero.
    always_comb begin
        mem_ad = '0;
        mem_d  = '0;
        mem_we = 1'b0;
        if (d_gnt) begin
            mem_ad = d_addr;
            mem_d  = d_wdata;
            mem_we = d_we;
        end else if (if_gnt) begin
            mem_ad = if_addr;
        end
    end

    // Counts data grants that made a pending fetch wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= '0;
        end else if (!if_req || if_gnt) begin
            streak_q <= '0;
        end else if (d_gnt && !streak_full) begin
            streak_q <= streak_q + STREAK_W'(1);
        end
    end

    // Stores complete at grant, so only reads carry a tag.
    always_comb begin
        tag_in       = '0;
        tag_in.valid = if_gnt || (d_gnt && !d_we);
        tag_in.owner = d_gnt ? OWN_D : OWN_IF;
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Returns are masked during reset so a read cut off mid-flight never surfaces.
    assign ret_valid = tag_out.valid && !reset;
    assign if_rvalid = ret_valid && (tag_out.owner == OWN_IF);
    assign d_rvalid  = ret_valid && (tag_out.owner == OWN_D);
    assign if_rdata  = if_rvalid ? mem_q : '0;
    assign d_rdata   = d_rvalid  ? mem_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural RAM, per-cycle reference model
// (priority with fairness limit, return queue keyed by due cycle, shadow
// memory) plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned MAX_STREAK = 4;

    bit          clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] mem_ad;
    logic [31:0] mem_d;
    logic        mem_we;
    logic [31:0] mem_q;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .RD_LAT     (RD_LAT),
        .MAX_STREAK (MAX_STREAK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_ad    (mem_ad),
        .mem_d     (mem_d),
        .mem_we    (mem_we),
        .mem_q     (mem_q)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 1) ? 32'hE3A01005 : 32'hA500_0000 + 32'(i);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // Behavioural single-port RAM with RD_LAT-cycle read latency.
    logic [31:0] ram [64];
    logic [31:0] rd_pipe [RD_LAT];
    bit          ram_ready = 1'b0;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
            for (int i = 0; i < int'(RD_LAT); i++) rd_pipe[i] <= '0;
            ram_ready <= 1'b1;
        end else begin
            if (mem_we) ram[mem_ad[7:2]] <= mem_d;
            rd_pipe[0] <= ram[mem_ad[7:2]];
            for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign mem_q = rd_pipe[RD_LAT-1];

    // Reference model: expected returns are queued with the cycle they fall due.
    typedef struct {
        int          due;
        logic        own_d;
        logic [31:0] data;
    } ret_t;

    ret_t        ret_q [$];
    logic [31:0] mmem [64];
    bit          mmem_ready = 1'b0;
    int          m_streak   = 0;
    logic        e_dg, e_ig, hit, hit_d;
    logic [31:0] hit_data;

    always @(negedge clk) begin
        if (!mmem_ready) begin
            for (int i = 0; i < 64; i++) mmem[i] = init_word(i);
            mmem_ready = 1'b1;
        end
        if (reset) begin
            chk("rst_if_gnt", 32'(if_gnt), 32'd0);
            chk("rst_d_gnt", 32'(d_gnt), 32'd0);
            chk("rst_mem_we", 32'(mem_we), 32'd0);
            chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
            chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
            ret_q.delete();
            m_streak = 0;
        end else begin
            e_dg = d_req && !(if_req && m_streak == int'(MAX_STREAK));
            e_ig = if_req && !e_dg;
            chk("m_if_gnt", 32'(if_gnt), 32'(e_ig));
            chk("m_d_gnt", 32'(d_gnt), 32'(e_dg));
            chk("m_mem_ad", mem_ad, e_dg ? d_addr : (e_ig ? if_addr : 32'd0));
            chk("m_mem_d", mem_d, e_dg ? d_wdata : 32'd0);
            chk("m_mem_we", 32'(mem_we), 32'(e_dg && d_we));
            hit      = (ret_q.size() > 0) && (ret_q[0].due == cyc);
            hit_d    = hit && ret_q[0].own_d;
            hit_data = hit ? ret_q[0].data : 32'd0;
            chk("m_if_rvalid", 32'(if_rvalid), 32'(hit && !hit_d));
            chk("m_d_rvalid", 32'(d_rvalid), 32'(hit_d));
            chk("m_if_rdata", if_rdata, (hit && !hit_d) ? hit_data : 32'd0);
            chk("m_d_rdata", d_rdata, hit_d ? hit_data : 32'd0);
            if (hit) void'(ret_q.pop_front());
            if (e_ig) ret_q.push_back('{cyc + int'(RD_LAT), 1'b0, mmem[if_addr[7:2]]});
            if (e_dg && !d_we) ret_q.push_back('{cyc + int'(RD_LAT), 1'b1, mmem[d_addr[7:2]]});
            if (e_dg && d_we) mmem[d_addr[7:2]] = d_wdata;
            if (!if_req || e_ig) m_streak = 0;
            else if (e_dg && m_streak < int'(MAX_STREAK)) m_streak++;
        end
        cyc++;
    end

    // Apply one cycle of inputs just after the edge; caller checks 3 time units later.
    task automatic drive(input logic rs, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dw, input logic [31:0] da,
                         input logic [31:0] dd);
        @(posedge clk);
        #1;
        reset = rs; if_req = ir; if_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        #3;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    logic [9:0] seq3 = 10'b1111011110;
    logic [7:0] seq4 = 8'b1111_1110;
    logic [4:0] seq6 = 5'b11110;
    logic       hold_if, hold_d;

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        // Requests during reset are ignored.
        repeat (3) drive(1'b1, 1'b1, 32'h4, 1'b1, 1'b1, 32'h8, 32'h5);
        idle();
        chk("post_rst_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("post_rst_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("post_rst_d_rdata", d_rdata, 32'd0);

        // Fetch only.
        drive(1'b0, 1'b1, 32'h04, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("t1_if_gnt", 32'(if_gnt), 32'd1);
        chk("t1_d_gnt", 32'(d_gnt), 32'd0);
        idle();
        chk("t1_early_if_rvalid", 32'(if_rvalid), 32'd0);
        idle();
        chk("t1_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("t1_if_rdata", if_rdata, 32'hE3A01005);
        chk("t1_d_rvalid", 32'(d_rvalid), 32'd0);

        // Store then load to the same word.
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
        chk("t2_st_gnt", 32'(d_gnt), 32'd1);
        chk("t2_st_we", 32'(mem_we), 32'd1);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h40, 32'd0);
        chk("t2_ld_we", 32'(mem_we), 32'd0);
        idle();
        chk("t2_st_no_rvalid", 32'(d_rvalid), 32'd0);
        idle();
        chk("t2_ld_rvalid", 32'(d_rvalid), 32'd1);
        chk("t2_ld_rdata", d_rdata, 32'hDEADBEEF);

        // Sustained contention: four data grants then one fetch.
        idle();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 32'hC, 32'd0);
            chk("t3_d_gnt", 32'(d_gnt), 32'(seq3[9-i]));
            chk("t3_if_gnt", 32'(if_gnt), 32'(!seq3[9-i]));
        end

        // Fetch dropping for a cycle restarts the streak.
        idle();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, (i != 2), 32'h8, 1'b1, 1'b0, 32'hC, 32'd0);
            chk("t4_d_gnt", 32'(d_gnt), 32'(seq4[7-i]));
        end

        // Alternating fetch/data loads every cycle.
        idle(); idle();
        for (int i = 0; i < 8; i++) begin
            if (i < 6) drive(1'b0, (i % 2 == 0), 32'(4 * (8 + i)),
                             (i % 2 == 1), 1'b0, 32'(4 * (8 + i)), 32'd0);
            else idle();
            if (i >= 2) begin
                chk("t5_if_rvalid", 32'(if_rvalid), 32'((i - 2) % 2 == 0));
                chk("t5_d_rvalid", 32'(d_rvalid), 32'((i - 2) % 2 == 1));
                chk("t5_rdata", ((i - 2) % 2 == 1) ? d_rdata : if_rdata, init_word(8 + i - 2));
            end
        end

        // Reset while reads are in flight; streak must restart afterwards.
        idle(); idle();
        drive(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h10, 32'd0);
        drive(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h10, 32'd0);
        drive(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h14, 32'd0);
        chk("t6_ld_gnt", 32'(d_gnt), 32'd1);
        drive(1'b1, 1'b1, 32'h4, 1'b1, 1'b1, 32'h14, 32'h1);
        chk("t6_rst_d_gnt", 32'(d_gnt), 32'd0);
        chk("t6_rst_if_gnt", 32'(if_gnt), 32'd0);
        chk("t6_rst_mem_we", 32'(mem_we), 32'd0);
        chk("t6_rst_d_rvalid", 32'(d_rvalid), 32'd0);
        idle();
        chk("t6_after_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("t6_after_d_rdata", d_rdata, 32'd0);
        chk("t6_after_if_rvalid", 32'(if_rvalid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h14, 32'd0);
            chk("t6_streak_d_gnt", 32'(d_gnt), 32'(seq6[4-i]));
        end
        idle();

        // Randomised traffic; requesters hold until granted.
        hold_if = 1'b0; hold_d = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            if (!hold_if) begin
                if_req  = ($urandom_range(0, 1) == 1);
                if_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (!hold_d) begin
                d_req   = ($urandom_range(0, 3) != 0);
                d_we    = ($urandom_range(0, 2) == 0);
                d_addr  = 32'($urandom_range(0, 15)) << 2;
                d_wdata = $urandom;
            end
            reset = ($urandom_range(0, 149) == 0);
            #3;
            hold_if = if_req && !if_gnt;
            hold_d  = d_req && !d_gnt;
        end
        idle(); idle(); idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous `ram` between the instruction-fetch path and the data (load/store) path, so data memory can use the same RAM instance as instruction memory.
- Grants at most one access per cycle. Data has priority, with a bounded-streak rule so fetch cannot starve.
- Tracks in-flight reads through a tag pipeline and returns each read to the requester that issued it.
- Sits between `cpu` and `ram`, replacing the direct `instr_addr_bus`/`instr_bus` hookup.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RD_LAT, 1, cycles from granted read to valid mem_q (≥1)
- MAX_STREAK, 4, max consecutive data grants while fetch is pending (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data access accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- mem_ad  out  ADDR_W  to ram .ad
- mem_d  out  DATA_W  to ram .d
- mem_we  out  1  to ram .we
- mem_q  in  DATA_W  from ram .q

Behaviour:
- Grant is combinational from the requests and the registered streak count, so a request is granted in the same cycle it is presented.
- if_gnt and d_gnt are never both 1.
- Grant rule:
  - d_req and not if_req: data wins.
  - if_req and not d_req: fetch wins.
  - Both asserted: data wins unless streak == MAX_STREAK, in which case fetch wins.
- Streak counter, width clog2(MAX_STREAK+1), updated at the clock edge:
  - +1 on a data grant while if_req=1.
  - Cleared on a fetch grant or whenever if_req=0.
  - Saturates at MAX_STREAK.
- Memory drive:
  - Fetch granted: mem_ad=if_addr, mem_we=0.
  - Data granted: mem_ad=d_addr, mem_d=d_wdata, mem_we=d_we.
  - Idle: mem_ad=0, mem_d=0, mem_we=0.
- Stores complete at grant. They produce no rvalid.
- Read tag pipeline: RD_LAT stages, each holding {valid, owner}.
  - A granted read (fetch, or data with d_we=0) enters stage 0.
  - Stage RD_LAT-1 drives the rvalid for its owner.
- Read return:
  - if_rvalid/d_rvalid pulse exactly RD_LAT cycles after the grant cycle.
  - The matching rdata is mem_q passed through combinationally.
  - The non-valid rdata output is driven to 0.
- Back-to-back grants every cycle are allowed. Returns arrive in grant order, with no reordering and no bubble insertion.
- Reset (reset=1 at a clock edge):
  - Pipeline valids and the streak counter are cleared.
  - While reset=1, if_gnt=d_gnt=0 and mem_we=0, regardless of requests.
  - First cycle after reset: if_rvalid=d_rvalid=0, rdata=0.
- Reset mid-read: in-flight reads are discarded and never return an rvalid.
- Requesters must hold req and the address/data stable until gnt. The arbiter does not latch unaccepted requests.

Decomposition:
- Shared package holds:
  - owner encoding constants OWN_IF=1'b0, OWN_D=1'b1
  - default ADDR_W/DATA_W
- One sub-module, `rd_tag_pipe`: a parameterised RD_LAT-deep shift register of {valid, owner}, with synchronous clear. Grant logic and the streak counter stay in the top.

Test Plan:
- Fetch only: if_req=1, if_addr=0x04; ram holds 0xE3A01005 at 0x04 → if_gnt=1 in cycle 0; if_rvalid=1 and if_rdata=0xE3A01005 in cycle 1 (RD_LAT=1); d_rvalid stays 0.
- Store then load: d_req=1, d_we=1, addr=0x40, wdata=0xDEADBEEF; next cycle d_we=0, addr=0x40 → mem_we=1 only in cycle 0; d_rvalid=1 with d_rdata=0xDEADBEEF in cycle 2.
- Contention fairness (MAX_STREAK=4): if_req and d_req held high for 10 cycles → grant sequence D,D,D,D,I,D,D,D,D,I.
- Streak clear: MAX_STREAK=4; if_req=1 for 2 data grants, then if_req=0 for 1 cycle, then if_req=1 with d_req still 1 → counter resets to 0; 4 more data grants before fetch.
- Interleaved reads with RD_LAT=2, alternating fetch/data loads every cycle → rvalids alternate owners 2 cycles after each grant, each with the correct data.
- Reset mid-read: grant a load at cycle 0, assert reset at cycle 1 → no d_rvalid at cycle 1 or 2; gnts=0 while reset=1; streak=0 afterwards.
